// File: rtl/clock_divider_pkg.sv
// Shared types and helpers for the gated multi-channel clock divider.
package clock_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int DIV_WIDTH_DEF = 8;

  // LSB position of channel ch's divisor field in the flattened divisor bus.
  function automatic int div_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: IDLE/RUN/STOP FSM, phase counter, latched divisor and a
// registered 50%-duty output that only changes at phase boundaries.
module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en_s_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 clk_o,
  output logic                 active_o
);

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 out_q, out_d;
  logic                 active_q;
  logic                 wrap;

  assign wrap = (cnt_q == div_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        out_d = 1'b0;
        if (en_s_i) begin
          state_d = RUN;
          div_d   = div_i;
        end
      end
      RUN, STOP: begin
        if (wrap) begin
          cnt_d = '0;
          out_d = ~out_q;
          // Divisor is only re-sampled at a full period boundary (falling toggle).
          if (out_q) div_d = div_i;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        // A disable that lands with the output high commits to finishing the high phase.
        if (state_q == RUN && !en_s_i) state_d = out_d ? STOP : IDLE;
        if (state_q == STOP && wrap && out_q) state_d = IDLE;
        if (state_d == IDLE) begin
          cnt_d = '0;
          out_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        out_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      out_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      out_q    <= out_d;
      active_q <= (state_d != IDLE);
    end
  end

  assign clk_o    = out_q;
  assign active_o = active_q;

endmodule

// File: rtl/clock_divider_gated.sv
// Multi-channel glitch-free programmable clock divider: per-channel enable
// synchronizer feeding an array of independent divider channels.
module clock_divider_gated
  import clock_divider_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int DIV_WIDTH    = DIV_WIDTH_DEF,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_CHANNELS-1:0]           enable,
  input  logic [NUM_CHANNELS*DIV_WIDTH-1:0] divisor,
  output logic [NUM_CHANNELS-1:0]           clock_out,
  output logic [NUM_CHANNELS-1:0]           active
);

  logic [NUM_CHANNELS-1:0] en_s;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    if (SYNC_STAGES == 0) begin : g_nosync
      assign en_s[i] = enable[i];
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= enable[i];
          for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
      end
      assign en_s[i] = sync_q[SYNC_STAGES-1];
    end

    clock_divider_channel #(
      .DIV_WIDTH(DIV_WIDTH)
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .en_s_i  (en_s[i]),
      .div_i   (divisor[div_lsb(i, DIV_WIDTH) +: DIV_WIDTH]),
      .clk_o   (clock_out[i]),
      .active_o(active[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_gated.sv
// Self-checking bench for clock_divider_gated: directed table, hand sequences and
// randomized traffic against a phase-length reference model.
module tb_clock_divider_gated;

  localparam int NC = 4;
  localparam int DW = 8;
  localparam int SS = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic [NC-1:0]   enable;
  logic [NC*DW-1:0] divisor;
  logic [NC-1:0]   clock_out;
  logic [NC-1:0]   active;

  int tests = 0;
  int fails = 0;

  clock_divider_gated #(
    .NUM_CHANNELS(NC), .DIV_WIDTH(DW), .SYNC_STAGES(SS)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .divisor(divisor),
    .clock_out(clock_out), .active(active)
  );

  always #5 clock = ~clock;

  // Reference model: each channel is "off", "on" or "draining"; it tracks the
  // current level and how many cycles remain in the current phase.
  typedef enum int {M_OFF, M_ON, M_DRAIN} mmode_t;
  mmode_t m_mode [NC];
  int     m_left [NC];
  int     m_d    [NC];
  bit     m_lvl  [NC];
  bit     m_dly  [NC][SS];

  function automatic int dsel(input int ch);
    return int'(divisor[ch*DW +: DW]);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_mode[c] = M_OFF; m_left[c] = 0; m_d[c] = 0; m_lvl[c] = 1'b0;
      for (int s = 0; s < SS; s++) m_dly[c][s] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NC; c++) begin
      bit ens, boundary;
      ens = m_dly[c][SS-1];
      for (int s = SS-1; s > 0; s--) m_dly[c][s] = m_dly[c][s-1];
      m_dly[c][0] = enable[c];
      boundary = 1'b0;
      if (m_mode[c] == M_OFF) begin
        if (ens) begin
          m_mode[c] = M_ON; m_lvl[c] = 1'b0; m_d[c] = dsel(c); m_left[c] = m_d[c] + 1;
        end
      end else begin
        m_left[c]--;
        if (m_left[c] == 0) begin
          m_lvl[c] = !m_lvl[c];
          if (!m_lvl[c]) begin
            m_d[c] = dsel(c);
            boundary = 1'b1;
          end
          m_left[c] = m_d[c] + 1;
        end
        if (m_mode[c] == M_ON && !ens) m_mode[c] = m_lvl[c] ? M_DRAIN : M_OFF;
        else if (m_mode[c] == M_DRAIN && boundary) m_mode[c] = M_OFF;
        if (m_mode[c] == M_OFF) m_lvl[c] = 1'b0;
      end
    end
  endtask

  task automatic chk(input string name, input int ch, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s ch%0d: got %0d want %0d at %0t", name, ch, act, exp, $time);
    end
  endtask

  task automatic model_check();
    for (int c = 0; c < NC; c++) begin
      chk("model_clock_out", c, int'(clock_out[c]), int'(m_lvl[c]));
      chk("model_active", c, int'(active[c]), int'(m_mode[c] != M_OFF));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    model_check();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    logic       en;
    logic [7:0] d;
    logic       exp_out;
    logic       exp_act;
  } vec_t;
  vec_t vt [15];

  int rise_prev [NC];
  int rise_last [NC];
  int first_act [NC];
  bit prev_out  [NC];

  initial begin
    // ch0, d=1, two-stage sync: enable for 7 edges, drop for 3 (lands in a
    // high phase -> drain), re-assert during the drain.
    vt[0]  = '{1'b1, 8'd1, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 8'd1, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 8'd1, 1'b0, 1'b1};
    vt[3]  = '{1'b1, 8'd1, 1'b0, 1'b1};
    vt[4]  = '{1'b1, 8'd1, 1'b1, 1'b1};
    vt[5]  = '{1'b1, 8'd1, 1'b1, 1'b1};
    vt[6]  = '{1'b1, 8'd1, 1'b0, 1'b1};
    vt[7]  = '{1'b0, 8'd1, 1'b0, 1'b1};
    vt[8]  = '{1'b0, 8'd1, 1'b1, 1'b1};
    vt[9]  = '{1'b0, 8'd1, 1'b1, 1'b1};
    vt[10] = '{1'b1, 8'd1, 1'b0, 1'b0};
    vt[11] = '{1'b1, 8'd1, 1'b0, 1'b0};
    vt[12] = '{1'b1, 8'd1, 1'b0, 1'b1};
    vt[13] = '{1'b1, 8'd1, 1'b0, 1'b1};
    vt[14] = '{1'b1, 8'd1, 1'b1, 1'b1};

    reset = 1'b1;
    enable = '0;
    divisor = '0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    for (int c = 0; c < NC; c++) begin
      chk("reset_clock_out", c, int'(clock_out[c]), 0);
      chk("reset_active", c, int'(active[c]), 0);
    end

    for (int k = 0; k < 15; k++) begin
      enable[0] = vt[k].en;
      divisor[7:0] = vt[k].d;
      tick();
      chk("table_clock_out", 0, int'(clock_out[0]), int'(vt[k].exp_out));
      chk("table_active", 0, int'(active[0]), int'(vt[k].exp_act));
    end

    // Independent periods and enable-to-active latency.
    enable = '0;
    do_reset();
    divisor = {8'd255, 8'd5, 8'd1, 8'd0};
    enable = '1;
    for (int c = 0; c < NC; c++) begin
      rise_prev[c] = -1; rise_last[c] = -1; first_act[c] = -1; prev_out[c] = 1'b0;
    end
    for (int t = 1; t <= 1200; t++) begin
      tick();
      for (int c = 0; c < NC; c++) begin
        if (active[c] && first_act[c] < 0) first_act[c] = t;
        if (clock_out[c] && !prev_out[c]) begin
          rise_prev[c] = rise_last[c];
          rise_last[c] = t;
        end
        prev_out[c] = clock_out[c];
      end
    end
    for (int c = 0; c < NC; c++) begin
      chk("enable_latency", c, first_act[c], 3);
      chk("period", c, rise_last[c] - rise_prev[c], 2 * (dsel(c) + 1));
    end

    // Async reset while every output is high; then restart with enable held.
    do_reset();
    divisor = {8'd1, 8'd1, 8'd1, 8'd1};
    enable = '1;
    repeat (5) tick();
    for (int c = 0; c < NC; c++) chk("pre_reset_high", c, int'(clock_out[c]), 1);
    #2;
    reset = 1'b1;
    #1;
    for (int c = 0; c < NC; c++) begin
      chk("async_reset_clock_out", c, int'(clock_out[c]), 0);
      chk("async_reset_active", c, int'(active[c]), 0);
    end
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (20) tick();

    // Randomized enables and divisor changes against the model.
    for (int t = 0; t < 2500; t++) begin
      if ($urandom_range(0, 29) == 0) begin
        int c;
        c = $urandom_range(0, NC-1);
        enable[c] = ~enable[c];
      end
      if ($urandom_range(0, 14) == 0) begin
        int c;
        c = $urandom_range(0, NC-1);
        divisor[c*DW +: DW] = DW'($urandom_range(0, 6));
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
